ps2_rx_fifo: RTL and testbench

Upstream receive stage for the keyboard Wishbone peripheral. It samples the asynchronous PS/2 clock and data lines from the keyboard and decodes 11-bit device-to-host frames into 8-bit scancodes. Valid scancodes are buffered in a first-word-fall-through FIFO, which the Wishbone register block drains through a valid/ready handshake. Sticky overflow and frame-error flags are exported for a status register.

---
 rtl/ps2_rx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a first-word-fall-through
// scancode FIFO and sticky overflow / frame-error flags.
// Optional feature macro: PS2_PARITY_CHECK_EN (reject frames with bad parity).
// Ports:
//   wb_clk_i, wb_rst_i     system clock, async active-high reset
//   ps2_clk_i, ps2_data_i  raw asynchronous PS/2 lines
//   code_o, code_valid_o   FIFO head and not-empty flag
//   code_ready_i           pop when code_valid_o=1
//   fifo_count_o           occupancy
//   overflow_o             sticky: scancode dropped on full FIFO
//   frame_err_o            sticky: frame aborted (timeout) or rejected
//   err_clr_i              clears both sticky flags (a set in the same cycle wins)
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    code_o,
    output logic                          code_valid_o,
    input  logic                          code_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic                          frame_err_o,
    input  logic                          err_clr_i
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronisers and edge detector. All idle high so reset makes no edge.
    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2, data_q;
    logic fall;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            data_q   <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_i;
            data_s2  <= data_s1;
            // data_q stays aligned with the registered fall pulse
            data_q   <= data_s2;
            fall     <= clk_prev & ~clk_s2;
        end
    end

    // Frame decoder
    state_t         state;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [TW-1:0]  idle_cnt;
    logic           timeout;
    logic           frame_ok;
    logic           push;
    logic           stop_err;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            par_bit <= 1'b0;
        else if (fall && state == PARITY)
            par_bit <= data_q;
    end

    // Odd parity: data bits plus parity bit hold an odd number of ones
    assign frame_ok = data_q & (^{shreg, par_bit});
`else
    assign frame_ok = data_q;
`endif

    assign timeout  = (state != IDLE) && !fall &&
                      (idle_cnt == TW'(TIMEOUT_CYCLES));
    assign push     = fall && (state == STOP) && frame_ok;
    assign stop_err = fall && (state == STOP) && !frame_ok;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            idle_cnt    <= '0;
            frame_err_o <= 1'b0;
        end else begin
            if (fall || state == IDLE)
                idle_cnt <= '0;
            else if (!timeout)
                idle_cnt <= idle_cnt + 1'b1;

            if (timeout || stop_err)
                frame_err_o <= 1'b1;
            else if (err_clr_i)
                frame_err_o <= 1'b0;

            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_q) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_q, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: state <= STOP;
                    STOP:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // FWFT FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign full         = (fifo_count_o == (CW+1)'(FIFO_DEPTH));
    assign code_valid_o = (fifo_count_o != '0);
    assign pop_ok       = code_ready_i && code_valid_o;
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign push_ok      = push && (!full || pop_ok);
    assign code_o       = mem[rd_ptr];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= 8'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;

            if (push_ok && !pop_ok)
                fifo_count_o <= fifo_count_o + 1'b1;
            else if (pop_ok && !push_ok)
                fifo_count_o <= fifo_count_o - 1'b1;

            if (push && !push_ok)
                overflow_o <= 1'b1;
            else if (err_clr_i)
                overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo.
// Drives PS/2 frames bit by bit and checks FIFO contents and sticky flags.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TO    = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    ps2_rx_fifo #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .ps2_clk_i(ps2_clk),
        .ps2_data_i(ps2_data),
        .code_o(code),
        .code_valid_o(code_valid),
        .code_ready_i(code_ready),
        .fifo_count_o(fifo_count),
        .overflow_o(overflow),
        .frame_err_o(frame_err),
        .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Send the first n bits of a frame, LSB first. With pop_stop the
    // consumer pops exactly in the cycle the stop bit pushes.
    task automatic send_bits(input logic [10:0] bits, input int n,
                             input bit pop_stop);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (5) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (pop_stop && i == 10) begin
                repeat (3) @(posedge clk);
                #1 code_ready = 1'b1;
                @(posedge clk);
                #1 code_ready = 1'b0;
                repeat (6) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1 ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop);
        send_bits({stop, par, d, 1'b0}, 11, 1'b0);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic pop1;
        #1 code_ready = 1'b1;
        @(posedge clk);
        #1 code_ready = 1'b0;
    endtask

    task automatic clr_flags;
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_code", 32'(code), 0);

        // Good frame 0x1C, parity 0; stop fall is captured inside send_bits
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 1'b0);
        chk("f1c_valid", 32'(code_valid), 1);
        chk("f1c_code", 32'(code), 32'h1C);
        chk("f1c_count", 32'(fifo_count), 1);
        chk("f1c_ferr", 32'(frame_err), 0);
        pop1();
        chk("f1c_popped", 32'(code_valid), 0);

        // Parity error frame
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_count", 32'(fifo_count), 0);
        chk("par_ferr", 32'(frame_err), 1);
        clr_flags();
`else
        chk("par_count", 32'(fifo_count), 1);
        chk("par_code", 32'(code), 32'h1C);
        chk("par_ferr", 32'(frame_err), 0);
        pop1();
`endif

        // Bad stop bit
        send_frame(8'h5A, ~^8'h5A, 1'b0);
        chk("stop_count", 32'(fifo_count), 0);
        chk("stop_ferr", 32'(frame_err), 1);
        clr_flags();
        chk("stop_clr", 32'(frame_err), 0);

        // Overflow: nine frames into eight entries
        for (int k = 1; k <= 9; k++)
            send_good(8'(k));
        chk("ovf_count", 32'(fifo_count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_ferr", 32'(frame_err), 0);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ovf_pop%0d", k), 32'(code), 32'(k));
            pop1();
        end
        chk("ovf_empty", 32'(code_valid), 0);
        clr_flags();
        chk("ovf_clr", 32'(overflow), 0);

        // Timeout: start plus three data bits then silence
        send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 4, 1'b0);
        chk("to_pre", 32'(frame_err), 0);
        repeat (TO + 20) @(posedge clk);
        #1;
        chk("to_ferr", 32'(frame_err), 1);
        chk("to_count", 32'(fifo_count), 0);
        clr_flags();
        send_good(8'hF0);
        chk("to_f0_code", 32'(code), 32'hF0);
        chk("to_f0_count", 32'(fifo_count), 1);
        chk("to_f0_ferr", 32'(frame_err), 0);
        pop1();

        // Reset in the middle of a frame
        send_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 5, 1'b0);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_good(8'h29);
        chk("mid_count", 32'(fifo_count), 1);
        chk("mid_code", 32'(code), 32'h29);
        chk("mid_ferr", 32'(frame_err), 0);
        chk("mid_ovf", 32'(overflow), 0);
        pop1();

        // Full FIFO, push and pop in the same cycle
        for (int k = 0; k < 8; k++)
            send_good(8'h10 + 8'(k));
        chk("fp_full", 32'(fifo_count), 8);
        send_bits({1'b1, ~^8'h33, 8'h33, 1'b0}, 11, 1'b1);
        chk("fp_count", 32'(fifo_count), 8);
        chk("fp_ovf", 32'(overflow), 0);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("fp_pop%0d", k), 32'(code), 32'h10 + 32'(k));
            pop1();
        end
        chk("fp_tail", 32'(code), 32'h33);
        pop1();
        chk("fp_empty", 32'(code_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
